// File: rtl/mole_sprite_render_if.sv
// Mole sprite signal bundle: control, video stream and sprite ROM bus.
// master drives stimulus/ROM data, slave is the renderer.
interface mole_sprite_render_if;
    logic        frame_tick;
    logic        pop;
    logic        hit;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_de;
    logic [11:0] bg_rgb;
    logic [14:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] rgb_out;
    logic        rgb_de;
    logic        hittable;
    logic        done;
    logic        escaped;

    modport master (
        output frame_tick, pop, hit, pos_x, pos_y,
        output pix_x, pix_y, pix_de, bg_rgb, rom_data,
        input  rom_addr, rgb_out, rgb_de, hittable, done, escaped
    );

    modport slave (
        input  frame_tick, pop, hit, pos_x, pos_y,
        input  pix_x, pix_y, pix_de, bg_rgb, rom_data,
        output rom_addr, rgb_out, rgb_de, hittable, done, escaped
    );
endinterface

// File: rtl/mole_sprite_render.sv
// Per-hole mole animator: pop-up life cycle FSM, sprite ROM addressing
// and 3-stage transparent-key compositing over the background pixel.
module mole_sprite_render #(
    parameter int SPR_W = 150,
    parameter int SPR_H = 200,
    parameter int RISE_STEP = 8,
    parameter int UP_FRAMES = 60,
    parameter logic [11:0] TRANS_KEY = 12'hF0F
) (
    input logic clk,
    input logic rst,
    mole_sprite_render_if.slave bus
);
    typedef enum logic [1:0] {
        HIDDEN,
        RISING,
        UP,
        FALLING
    } state_t;

    localparam logic [10:0] W11 = 11'(SPR_W);
    localparam logic [10:0] H11 = 11'(SPR_H);
    localparam logic [10:0] RS11 = 11'(RISE_STEP);
    localparam logic [15:0] UPM1 = 16'(UP_FRAMES - 1);

    state_t      state, state_n;
    logic [10:0] rise, rise_n, sum;
    logic [15:0] up_cnt, up_n;
    logic [9:0]  px, px_n, py, py_n;
    logic        hit_flag, hf_n;
    logic        done, done_n;
    logic        escaped, esc_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HIDDEN;
            rise     <= '0;
            up_cnt   <= '0;
            px       <= '0;
            py       <= '0;
            hit_flag <= 1'b0;
            done     <= 1'b0;
            escaped  <= 1'b0;
        end else begin
            state    <= state_n;
            rise     <= rise_n;
            up_cnt   <= up_n;
            px       <= px_n;
            py       <= py_n;
            hit_flag <= hf_n;
            done     <= done_n;
            escaped  <= esc_n;
        end
    end

    // A hit takes priority over a same-cycle frame tick; rise is frozen then.
    always_comb begin
        state_n = state;
        rise_n  = rise;
        up_n    = up_cnt;
        px_n    = px;
        py_n    = py;
        hf_n    = hit_flag;
        done_n  = 1'b0;
        esc_n   = escaped;
        sum     = rise + RS11;
        unique case (state)
            HIDDEN: begin
                if (bus.pop) begin
                    state_n = RISING;
                    px_n    = bus.pos_x;
                    py_n    = bus.pos_y;
                    hf_n    = 1'b0;
                    rise_n  = '0;
                end
            end
            RISING: begin
                if (bus.hit) begin
                    state_n = FALLING;
                    hf_n    = 1'b1;
                end else if (bus.frame_tick) begin
                    if (sum >= H11) begin
                        rise_n  = H11;
                        up_n    = '0;
                        state_n = UP;
                    end else begin
                        rise_n = sum;
                    end
                end
            end
            UP: begin
                if (bus.hit) begin
                    state_n = FALLING;
                    hf_n    = 1'b1;
                end else if (bus.frame_tick) begin
                    if (up_cnt == UPM1) begin
                        state_n = FALLING;
                    end else begin
                        up_n = up_cnt + 16'd1;
                    end
                end
            end
            FALLING: begin
                if (bus.frame_tick) begin
                    if (rise <= RS11) begin
                        rise_n  = '0;
                        state_n = HIDDEN;
                        done_n  = 1'b1;
                        esc_n   = ~hit_flag;
                    end else begin
                        rise_n = rise - RS11;
                    end
                end
            end
            default: state_n = HIDDEN;
        endcase
    end

    // Sprite bottom is pinned to the hole bottom and slides up by rise.
    logic [10:0] x0, x1, ybot, ytop, xi, yi, srow, col;
    logic        in_box;
    logic [14:0] addr_c;

    always_comb begin
        x0     = {1'b0, px};
        x1     = x0 + W11;
        ybot   = {1'b0, py} + H11;
        ytop   = ybot - rise;
        xi     = {1'b0, bus.pix_x};
        yi     = {1'b0, bus.pix_y};
        srow   = yi - ytop;
        col    = xi - x0;
        in_box = bus.pix_de && (state != HIDDEN)
              && (xi >= x0) && (xi < x1)
              && (yi >= ytop) && (yi < ybot);
        addr_c = 15'(srow) * 15'(SPR_W) + 15'(col);
    end

    logic [14:0] rom_addr;
    logic        s1_box, s1_de, s2_box, s2_de;
    logic [11:0] s1_bg, s2_bg;
    logic [11:0] rgb_out;
    logic        rgb_de;

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            s1_box   <= 1'b0;
            s1_de    <= 1'b0;
            s1_bg    <= '0;
            s2_box   <= 1'b0;
            s2_de    <= 1'b0;
            s2_bg    <= '0;
            rgb_out  <= '0;
            rgb_de   <= 1'b0;
        end else begin
            if (in_box) rom_addr <= addr_c;
            s1_box <= in_box;
            s1_de  <= bus.pix_de;
            s1_bg  <= bus.bg_rgb;
            s2_box <= s1_box;
            s2_de  <= s1_de;
            s2_bg  <= s1_bg;
            rgb_de <= s2_de;
            if (!s2_de) begin
                rgb_out <= '0;
            end else if (s2_box && (bus.rom_data != TRANS_KEY)) begin
                rgb_out <= bus.rom_data;
            end else begin
                rgb_out <= s2_bg;
            end
        end
    end

    assign bus.rom_addr = rom_addr;
    assign bus.rgb_out  = rgb_out;
    assign bus.rgb_de   = rgb_de;
    assign bus.hittable = (state == RISING) || (state == UP);
    assign bus.done     = done;
    assign bus.escaped  = escaped;
endmodule

// File: tb/tb_mole_sprite_render.sv
// Directed bench for mole_sprite_render: life cycle, window/address,
// transparency keying, hit priority and ignored commands.
module tb_mole_sprite_render;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [11:0] rom_303 = 12'h3A5;

    mole_sprite_render_if bus ();

    mole_sprite_render dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Registered ROM: only address 303 carries the test texel.
    always @(posedge clk)
        bus.rom_data <= (bus.rom_addr == 15'd303) ? rom_303 : 12'h111;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic do_pop(input logic [9:0] x, input logic [9:0] y);
        bus.pos_x = x;
        bus.pos_y = y;
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
    endtask

    task automatic set_pix(input logic [9:0] x, input logic [9:0] y,
                           input logic de);
        bus.pix_x = x;
        bus.pix_y = y;
        bus.pix_de = de;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (bus.rom_addr !== 15'd0 || bus.rgb_out !== 12'd0 ||
            bus.rgb_de !== 1'b0 || bus.done !== 1'b0 ||
            bus.escaped !== 1'b0 || bus.hittable !== 1'b0) begin
            failures++;
            $display("FAIL reset_state addr=%0d rgb=%h de=%b done=%b esc=%b hit=%b req all 0",
                     bus.rom_addr, bus.rgb_out, bus.rgb_de, bus.done,
                     bus.escaped, bus.hittable);
        end
    endtask

    task automatic test_lifecycle();
        logic seen_done;
        do_pop(10'd100, 10'd50);
        checks++;
        if (bus.hittable !== 1'b1 || dut.rise !== 11'd0) begin
            failures++;
            $display("FAIL pop_rising hit=%b rise=%0d req 1/0", bus.hittable, dut.rise);
        end
        tick();
        checks++;
        if (dut.rise !== 11'd8) begin
            failures++;
            $display("FAIL rise_tick1 got=%0d req=8", dut.rise);
        end
        for (int k = 2; k <= 24; k++) tick();
        checks++;
        if (dut.rise !== 11'd192 || dut.state !== 2'd1) begin
            failures++;
            $display("FAIL rise_tick24 rise=%0d st=%0d req 192/1", dut.rise, dut.state);
        end
        tick();
        checks++;
        if (dut.rise !== 11'd200 || dut.state !== 2'd2) begin
            failures++;
            $display("FAIL up_tick25 rise=%0d st=%0d req 200/2", dut.rise, dut.state);
        end
        for (int k = 1; k <= 59; k++) tick();
        checks++;
        if (bus.hittable !== 1'b1) begin
            failures++;
            $display("FAIL up_59 hittable=%b req=1", bus.hittable);
        end
        tick();
        checks++;
        if (bus.hittable !== 1'b0 || dut.rise !== 11'd200) begin
            failures++;
            $display("FAIL up_timeout hit=%b rise=%0d req 0/200", bus.hittable, dut.rise);
        end
        seen_done = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0 || dut.rise !== 11'd8) begin
            failures++;
            $display("FAIL fall_24 done_seen=%b rise=%0d req 0/8", seen_done, dut.rise);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.escaped !== 1'b1 || dut.rise !== 11'd0) begin
            failures++;
            $display("FAIL escape_done done=%b esc=%b rise=%0d req 1/1/0",
                     bus.done, bus.escaped, dut.rise);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.escaped !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse done=%b esc=%b req 0/1", bus.done, bus.escaped);
        end
    endtask

    task automatic test_pixel();
        do_pop(10'd100, 10'd50);
        for (int k = 1; k <= 25; k++) tick();
        bus.bg_rgb = 12'h0C0;
        rom_303 = 12'h3A5;
        set_pix(10'd103, 10'd52, 1'b1);
        step();
        checks++;
        if (bus.rom_addr !== 15'd303) begin
            failures++;
            $display("FAIL addr_303 got=%0d req=303", bus.rom_addr);
        end
        step();
        step();
        checks++;
        if (bus.rgb_out !== 12'h3A5 || bus.rgb_de !== 1'b1) begin
            failures++;
            $display("FAIL sprite_px rgb=%h de=%b req 3a5/1", bus.rgb_out, bus.rgb_de);
        end
        rom_303 = 12'hF0F;
        step();
        step();
        step();
        checks++;
        if (bus.rgb_out !== 12'h0C0) begin
            failures++;
            $display("FAIL transparent rgb=%h req=0c0", bus.rgb_out);
        end
        rom_303 = 12'h3A5;
        set_pix(10'd99, 10'd52, 1'b1);
        step();
        step();
        step();
        checks++;
        if (bus.rgb_out !== 12'h0C0 || bus.rom_addr !== 15'd303) begin
            failures++;
            $display("FAIL left_of_box rgb=%h addr=%0d req 0c0/303",
                     bus.rgb_out, bus.rom_addr);
        end
        set_pix(10'd103, 10'd52, 1'b0);
        step();
        step();
        step();
        checks++;
        if (bus.rgb_out !== 12'h000 || bus.rgb_de !== 1'b0) begin
            failures++;
            $display("FAIL blank rgb=%h de=%b req 000/0", bus.rgb_out, bus.rgb_de);
        end
    endtask

    task automatic test_reset_mid_up();
        set_pix(10'd99, 10'd52, 1'b1);
        tick();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if (bus.hittable !== 1'b0 || dut.rise !== 11'd0 ||
            bus.rgb_out !== 12'd0 || bus.rgb_de !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_up hit=%b rise=%0d rgb=%h de=%b done=%b req all 0",
                     bus.hittable, dut.rise, bus.rgb_out, bus.rgb_de, bus.done);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.hittable !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_done done=%b hit=%b req 0/0", bus.done, bus.hittable);
        end
    endtask

    task automatic test_rise8();
        do_pop(10'd100, 10'd50);
        tick();
        bus.bg_rgb = 12'h0C0;
        set_pix(10'd103, 10'd241, 1'b1);
        step();
        step();
        step();
        checks++;
        if (bus.rgb_out !== 12'h0C0) begin
            failures++;
            $display("FAIL above_top rgb=%h req=0c0", bus.rgb_out);
        end
        set_pix(10'd103, 10'd242, 1'b1);
        step();
        checks++;
        if (bus.rom_addr !== 15'd3) begin
            failures++;
            $display("FAIL top_row_addr got=%0d req=3", bus.rom_addr);
        end
        step();
        step();
        checks++;
        if (bus.rgb_out !== 12'h111) begin
            failures++;
            $display("FAIL top_row_rgb got=%h req=111", bus.rgb_out);
        end
        bus.pix_de = 1'b0;
    endtask

    task automatic test_hit_tick();
        for (int k = 1; k <= 4; k++) tick();
        bus.hit = 1'b1;
        bus.frame_tick = 1'b1;
        step();
        bus.hit = 1'b0;
        bus.frame_tick = 1'b0;
        checks++;
        if (bus.hittable !== 1'b0 || dut.rise !== 11'd40) begin
            failures++;
            $display("FAIL hit_wins hit=%b rise=%0d req 0/40", bus.hittable, dut.rise);
        end
        for (int k = 1; k <= 4; k++) tick();
        checks++;
        if (bus.done !== 1'b0 || dut.rise !== 11'd8) begin
            failures++;
            $display("FAIL hit_fall4 done=%b rise=%0d req 0/8", bus.done, dut.rise);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.escaped !== 1'b0) begin
            failures++;
            $display("FAIL hit_done done=%b esc=%b req 1/0", bus.done, bus.escaped);
        end
    endtask

    task automatic test_ignored();
        do_pop(10'd100, 10'd50);
        for (int k = 1; k <= 25; k++) tick();
        set_pix(10'd100, 10'd50, 1'b1);
        step();
        checks++;
        if (bus.rom_addr !== 15'd0) begin
            failures++;
            $display("FAIL corner_addr got=%0d req=0", bus.rom_addr);
        end
        do_pop(10'd300, 10'd50);
        set_pix(10'd103, 10'd52, 1'b1);
        step();
        checks++;
        if (bus.hittable !== 1'b1 || bus.rom_addr !== 15'd303 || dut.rise !== 11'd200) begin
            failures++;
            $display("FAIL pop_in_up hit=%b addr=%0d rise=%0d req 1/303/200",
                     bus.hittable, bus.rom_addr, dut.rise);
        end
        bus.pix_de = 1'b0;
        bus.hit = 1'b1;
        step();
        bus.hit = 1'b0;
        for (int k = 1; k <= 25; k++) tick();
        checks++;
        if (bus.done !== 1'b1 || bus.escaped !== 1'b0) begin
            failures++;
            $display("FAIL hit_up_done done=%b esc=%b req 1/0", bus.done, bus.escaped);
        end
        bus.hit = 1'b1;
        tick();
        bus.hit = 1'b0;
        checks++;
        if (bus.hittable !== 1'b0 || dut.rise !== 11'd0 || bus.escaped !== 1'b0) begin
            failures++;
            $display("FAIL hit_hidden hit=%b rise=%0d esc=%b req 0/0/0",
                     bus.hittable, dut.rise, bus.escaped);
        end
        do_pop(10'd100, 10'd50);
        checks++;
        if (bus.hittable !== 1'b1) begin
            failures++;
            $display("FAIL pop_after hit=%b req=1", bus.hittable);
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.pop = 1'b0;
        bus.hit = 1'b0;
        bus.pos_x = '0;
        bus.pos_y = '0;
        bus.pix_x = '0;
        bus.pix_y = '0;
        bus.pix_de = 1'b0;
        bus.bg_rgb = '0;
        test_reset();
        test_lifecycle();
        test_pixel();
        test_reset_mid_up();
        test_rise8();
        test_hit_tick();
        test_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
